// File: rtl/serpent_subkey_buffer.sv
// serpent_subkey_buffer: captures the 33 Serpent subkeys and streams them to the round engine in key order.
module serpent_subkey_buffer #(
    parameter int NUM_SUBKEYS = 33,
    parameter int KEY_W       = 128,
    parameter int ADDR_W      = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [KEY_W-1:0]  i_wr_subkey,
    input  logic              i_sched_done,
    input  logic              i_start,
    input  logic              i_decrypt,
    input  logic              i_ready,
    output logic [KEY_W-1:0]  o_subkey,
    output logic [ADDR_W-1:0] o_round,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_keys_ready,
    output logic              o_busy,
    output logic              o_err
);
    typedef enum logic [1:0] {EMPTY, LOADED, STREAM} state_t;
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(NUM_SUBKEYS - 1);
    localparam logic [NUM_SUBKEYS-1:0] ONLY_FIRST = {{(NUM_SUBKEYS-1){1'b0}}, 1'b1};
    state_t                   state;
    logic [KEY_W-1:0]         mem [NUM_SUBKEYS];
    logic [NUM_SUBKEYS-1:0]   mask;
    logic                     dec;
    logic                     wr_ok;
    logic [ADDR_W-1:0]        nxt;
    logic [ADDR_W-1:0]        end_idx;
    logic [ADDR_W-1:0]        start_idx;
    always_comb begin
        wr_ok     = i_wr_en && (i_wr_addr <= TOP) && (state != STREAM);
        nxt       = dec ? o_round - ADDR_W'(1) : o_round + ADDR_W'(1);
        end_idx   = dec ? '0 : TOP;
        start_idx = i_decrypt ? TOP : '0;
    end
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[i_wr_addr] <= i_wr_subkey;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= EMPTY;
            mask         <= '0;
            dec          <= 1'b0;
            o_subkey     <= '0;
            o_round      <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_keys_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            // A start is only legal in LOADED with no competing write.
            if ((i_wr_en && !wr_ok) || (i_start && (state != LOADED || i_wr_en))) o_err <= 1'b1;
            case (state)
                EMPTY: begin
                    if (wr_ok) mask[i_wr_addr] <= 1'b1;
                    if (i_sched_done && &mask) begin
                        state        <= LOADED;
                        o_keys_ready <= 1'b1;
                    end else if (i_sched_done) begin
                        o_err <= 1'b1;
                    end
                end
                LOADED: begin
                    if (wr_ok && i_wr_addr == '0) begin
                        mask         <= ONLY_FIRST;
                        state        <= EMPTY;
                        o_keys_ready <= 1'b0;
                    end else if (i_start && !i_wr_en) begin
                        dec          <= i_decrypt;
                        o_round      <= start_idx;
                        o_subkey     <= mem[start_idx];
                        o_valid      <= 1'b1;
                        o_busy       <= 1'b1;
                        o_last       <= 1'b0;
                        o_keys_ready <= 1'b0;
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (o_valid && i_ready && o_last) begin
                        o_valid      <= 1'b0;
                        o_busy       <= 1'b0;
                        o_last       <= 1'b0;
                        o_keys_ready <= 1'b1;
                        state        <= LOADED;
                    end else if (o_valid && i_ready) begin
                        o_round  <= nxt;
                        o_subkey <= mem[nxt];
                        o_last   <= (nxt == end_idx);
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
